// File: rtl/imem_responder_if.sv
// Fetch-side bus between the fetch stage (master) and the instruction memory responder (slave):
// a valid/ready request channel carrying the address and a valid/ready response channel carrying the word.
interface imem_responder_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic              resp_err;

    modport master (
        output req_valid, req_addr, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_addr, resp_ready,
        output req_ready, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: serves fetch requests from a programmable word array.
// Optional wait states are built only when IMEM_WAIT_STATES_EN is defined.
module imem_responder #(
    parameter int              ADDR_W   = 16,
    parameter int              DATA_W   = 16,
    parameter int              DEPTH    = 256,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    imem_responder_if.slave   bus,
    input  logic              flush,
    input  logic [3:0]        wait_cfg,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data
);

    localparam int              IDX_W   = $clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] resp_data_q;
    logic              resp_err_q;
    logic [DATA_W-1:0] rd_word;
    logic              rd_err;
    logic              prog_ok;
    logic              req_ready;
    logic              accept;
    logic              go_wait;

`ifdef IMEM_WAIT_STATES_EN
    logic [3:0]        cnt;
    logic [DATA_W-1:0] pend_data;
    logic              pend_err;

    assign go_wait = (wait_cfg != 4'd0);
`else
    logic unused_wait_cfg;

    assign unused_wait_cfg = ^wait_cfg;
    assign go_wait         = 1'b0;
`endif

    assign prog_ok   = ({1'b0, prog_addr} < DEPTH_L);
    assign rd_err    = !({1'b0, bus.req_addr} < DEPTH_L);
    assign rd_word   = rd_err ? NOP_WORD : mem[bus.req_addr[IDX_W-1:0]];
    assign req_ready = !flush && ((state == IDLE) || ((state == RESP) && bus.resp_ready));
    assign accept    = bus.req_valid && req_ready;

    assign bus.req_ready  = req_ready;
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_err   = resp_err_q;

    // Array is intentionally not reset; a same-edge fetch sees the old word.
    always_ff @(posedge clk) begin
        if (prog_we && prog_ok) begin
            mem[prog_addr[IDX_W-1:0]] <= prog_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (flush) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) next_state = go_wait ? WAIT : RESP;
                end
                RESP: begin
                    if (bus.resp_ready) next_state = accept ? (go_wait ? WAIT : RESP) : IDLE;
                end
`ifdef IMEM_WAIT_STATES_EN
                WAIT: begin
                    if (cnt == 4'd1) next_state = RESP;
                end
`endif
                default: next_state = IDLE;
            endcase
        end
    end

    // Response registers only update on entry to RESP; delayed fetches park in pend_* meanwhile.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_data_q <= NOP_WORD;
            resp_err_q  <= 1'b0;
`ifdef IMEM_WAIT_STATES_EN
            cnt         <= 4'd0;
            pend_data   <= NOP_WORD;
            pend_err    <= 1'b0;
`endif
        end else begin
            if (accept && !go_wait) begin
                resp_data_q <= rd_word;
                resp_err_q  <= rd_err;
            end
`ifdef IMEM_WAIT_STATES_EN
            if (accept && go_wait) begin
                pend_data <= rd_word;
                pend_err  <= rd_err;
                cnt       <= wait_cfg;
            end else if (flush) begin
                cnt <= 4'd0;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
                if (cnt == 4'd1) begin
                    resp_data_q <= pend_data;
                    resp_err_q  <= pend_err;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Directed self-checking bench for imem_responder; wait-state steps run only with IMEM_WAIT_STATES_EN.
module tb_imem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [3:0]  wait_cfg;
    logic        prog_we;
    logic [15:0] prog_addr;
    logic [15:0] prog_data;
    int          passed = 0;
    int          total  = 0;

    imem_responder_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    imem_responder #(
        .ADDR_W(16), .DATA_W(16), .DEPTH(256), .NOP_WORD(16'h0000)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .flush(flush),
        .wait_cfg(wait_cfg),
        .prog_we(prog_we),
        .prog_addr(prog_addr),
        .prog_data(prog_data)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    endtask

    logic [15:0] words [4];

    initial begin
        words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333; words[3] = 16'h4444;
        rst_n = 1'b1; flush = 1'b0; wait_cfg = 4'd0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        bus.req_valid = 1'b0; bus.req_addr = '0; bus.resp_ready = 1'b0;
        #2 rst_n = 1'b0;
        tick();
        check_output("reset_valid", 32'(bus.resp_valid), 32'd0);
        check_output("reset_data",  32'(bus.resp_data),  32'h0000);
        check_output("reset_err",   32'(bus.resp_err),   32'd0);
        tick();
        rst_n = 1'b1;
        #1 check_output("reset_req_ready", 32'(bus.req_ready), 32'd1);

        $display("[TB] program words 0..3");
        tick();
        for (int i = 0; i < 4; i++) begin
            prog_we = 1'b1; prog_addr = 16'(i); prog_data = words[i];
            tick();
        end
        prog_we = 1'b0;

        $display("[TB] back-to-back fetches, W=0");
        bus.resp_ready = 1'b1;
        bus.req_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.req_addr = 16'(i);
            #1 check_output($sformatf("burst_ready_%0d", i), 32'(bus.req_ready), 32'd1);
            tick();
            check_output($sformatf("burst_valid_%0d", i), 32'(bus.resp_valid), 32'd1);
            check_output($sformatf("burst_data_%0d", i),  32'(bus.resp_data),  32'(words[i]));
        end
        bus.req_valid = 1'b0;
        tick();
        check_output("burst_idle", 32'(bus.resp_valid), 32'd0);

        $display("[TB] out-of-range fetch");
        bus.req_valid = 1'b1; bus.req_addr = 16'h0100;
        tick();
        bus.req_valid = 1'b0;
        check_output("oor_valid", 32'(bus.resp_valid), 32'd1);
        check_output("oor_data",  32'(bus.resp_data),  32'h0000);
        check_output("oor_err",   32'(bus.resp_err),   32'd1);
        tick();

        $display("[TB] back-pressure");
        bus.resp_ready = 1'b0;
        bus.req_valid = 1'b1; bus.req_addr = 16'd2;
        tick();
        bus.req_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_output($sformatf("bp_valid_%0d", k), 32'(bus.resp_valid), 32'd1);
            check_output($sformatf("bp_data_%0d", k),  32'(bus.resp_data),  32'h3333);
            check_output($sformatf("bp_err_%0d", k),   32'(bus.resp_err),   32'd0);
            check_output($sformatf("bp_ready_%0d", k), 32'(bus.req_ready),  32'd0);
            tick();
        end
        bus.resp_ready = 1'b1;
        #1 check_output("bp_release_ready", 32'(bus.req_ready), 32'd1);
        tick();
        check_output("bp_done", 32'(bus.resp_valid), 32'd0);

`ifdef IMEM_WAIT_STATES_EN
        $display("[TB] wait states W=3");
        wait_cfg = 4'd3;
        bus.req_valid = 1'b1; bus.req_addr = 16'd1;
        tick();
        bus.req_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_output($sformatf("ws_valid_%0d", k), 32'(bus.resp_valid), 32'd0);
            check_output($sformatf("ws_ready_%0d", k), 32'(bus.req_ready),  32'd0);
            check_output($sformatf("ws_hold_%0d", k),  32'(bus.resp_data),  32'h3333);
            tick();
        end
        check_output("ws_valid", 32'(bus.resp_valid), 32'd1);
        check_output("ws_data",  32'(bus.resp_data),  32'h2222);
        tick();
`endif

        $display("[TB] flush after accept");
        wait_cfg = 4'd3;
        bus.req_valid = 1'b1; bus.req_addr = 16'd3;
        tick();
        bus.req_valid = 1'b0;
        flush = 1'b1;
        #1 check_output("flush1_ready", 32'(bus.req_ready), 32'd0);
        tick();
        flush = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_output($sformatf("flush1_none_%0d", k), 32'(bus.resp_valid), 32'd0);
            tick();
        end

        $display("[TB] flush in RESP");
        wait_cfg = 4'd0;
        bus.req_valid = 1'b1; bus.req_addr = 16'd0;
        tick();
        check_output("flush2_pre_valid", 32'(bus.resp_valid), 32'd1);
        bus.req_addr = 16'd1;
        flush = 1'b1;
        #1 check_output("flush2_ready", 32'(bus.req_ready), 32'd0);
        tick();
        flush = 1'b0; bus.req_valid = 1'b0;
        check_output("flush2_valid", 32'(bus.resp_valid), 32'd0);
        tick();
        check_output("flush2_no_accept", 32'(bus.resp_valid), 32'd0);

        $display("[TB] read/write collision");
        bus.req_valid = 1'b1; bus.req_addr = 16'd0;
        prog_we = 1'b1; prog_addr = 16'd0; prog_data = 16'hBEEF;
        tick();
        prog_we = 1'b0;
        check_output("coll_old", 32'(bus.resp_data), 32'h1111);
        tick();
        bus.req_valid = 1'b0;
        check_output("coll_new", 32'(bus.resp_data), 32'hBEEF);
        tick();

        $display("[TB] reset mid-fetch");
`ifdef IMEM_WAIT_STATES_EN
        wait_cfg = 4'd5;
        bus.req_valid = 1'b1; bus.req_addr = 16'd2;
        tick();
        bus.req_valid = 1'b0;
        check_output("rst_pre_wait", 32'(bus.resp_valid), 32'd0);
`else
        bus.resp_ready = 1'b0;
        bus.req_valid = 1'b1; bus.req_addr = 16'd2;
        tick();
        bus.req_valid = 1'b0;
        check_output("rst_pre_valid", 32'(bus.resp_valid), 32'd1);
`endif
        #1 rst_n = 1'b0;
        #1;
        check_output("rst_mid_valid", 32'(bus.resp_valid), 32'd0);
        check_output("rst_mid_data",  32'(bus.resp_data),  32'h0000);
        check_output("rst_mid_err",   32'(bus.resp_err),   32'd0);
        tick();
        rst_n = 1'b1; bus.resp_ready = 1'b1;
        #1 check_output("rst_release_ready", 32'(bus.req_ready), 32'd1);
        tick();
        check_output("rst_release_idle", 32'(bus.resp_valid), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
